prog_loader: RTL and testbench

- Serial program loader that sits directly upstream of the 8192x16 program memory.
- Consumes a byte stream from the UART receiver, parses a framed image and drives the memory write port (address/data/clock-enable).
- Holds the CPU while a load is in progress and releases it on a good checksum.
- Out of reset the CPU runs from the memory's initialised image; the loader only takes over when a frame arrives.

---
 rtl/prog_loader_if.sv | 22 ++
 rtl/prog_loader.sv | 174 +++++++++++++++++
 tb/tb_prog_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the serial program loader.
interface prog_loader_if #(
   parameter int ADDR_WIDTH = 13
) ();
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [15:0]           wr_data;

   // Environment side: UART receiver drives bytes, memory consumes writes.
   modport master (
      output rx_data, rx_valid,
      input  wr_en, wr_addr, wr_data
   );

   // Loader side.
   modport slave (
      input  rx_data, rx_valid,
      output wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: parses SYNC/LEN/DATA/CHK frames from a byte stream,
// writes 16-bit words into program memory and holds the CPU while loading.
module prog_loader #(
   parameter int         ADDR_WIDTH     = 13,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 2700000
) (
   input  logic            clk,
   input  logic            rst_n,
   prog_loader_if.slave    bus,
   output logic            cpu_hold,
   output logic            busy,
   output logic            load_done,
   output logic            load_error
);

   // Word counter / length are one bit wider so a full 2**ADDR_WIDTH image fits.
   localparam int          CW      = ADDR_WIDTH + 1;
   localparam int          TW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [CW-1:0]         len_q, len_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [7:0]            data_hi_q, data_hi_d;
   logic [7:0]            chk_q, chk_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]           wr_data_q, wr_data_d;
   logic                  hold_q, hold_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [15:0]           n_len;
   logic                  len_bad;

   assign n_len   = {len_hi_q, bus.rx_data};
   assign len_bad = (n_len == 16'd0) || ({1'b0, n_len} > MAX_LEN);

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign cpu_hold    = hold_q;
   assign busy        = busy_q;
   assign load_done   = done_q;
   assign load_error  = err_q;

   // Frame parser, write issue and inter-byte timeout.
   always_comb begin
      state_d   = state_q;
      len_hi_d  = len_hi_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      data_hi_d = data_hi_q;
      chk_d     = chk_q;
      tmo_d     = '0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      hold_d    = hold_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;

      case (state_q)
         S_IDLE: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
            state_d = S_LEN_HI;
            busy_d  = 1'b1;
            hold_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            chk_d   = '0;
            cnt_d   = '0;
         end
         S_LEN_HI: if (bus.rx_valid) begin
            len_hi_d = bus.rx_data;
            state_d  = S_LEN_LO;
         end
         S_LEN_LO: if (bus.rx_valid) begin
            if (len_bad) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               len_d   = CW'(n_len);
               state_d = S_DATA_HI;
            end
         end
         S_DATA_HI: if (bus.rx_valid) begin
            data_hi_d = bus.rx_data;
            chk_d     = chk_q + bus.rx_data;
            state_d   = S_DATA_LO;
         end
         S_DATA_LO: if (bus.rx_valid) begin
            chk_d     = chk_q + bus.rx_data;
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
            wr_data_d = {data_hi_q, bus.rx_data};
            if (cnt_q + CW'(1) == len_q) begin
               state_d = S_CHECK;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = S_DATA_HI;
            end
         end
         S_CHECK: if (bus.rx_valid) begin
            if (bus.rx_data == chk_q) begin
               done_d = 1'b1;
               hold_d = 1'b0;
            end else begin
               err_d  = 1'b1;
            end
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A byte always clears the counter, so a byte on the expiry cycle wins.
      // Expiry fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
      if (state_q != S_IDLE && !bus.rx_valid) begin
         if (tmo_q == TW'(TIMEOUT_CYCLES - 2)) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

   // State and output registers; reset drops any in-flight write and frees the CPU.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         len_hi_q  <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         data_hi_q <= '0;
         chk_q     <= '0;
         tmo_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         hold_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_hi_q  <= len_hi_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         data_hi_q <= data_hi_d;
         chk_q     <= chk_d;
         tmo_q     <= tmo_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         hold_q    <= hold_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, length limits, full image,
// timeout, noise with embedded sync bytes and asynchronous reset mid-frame.
module tb_prog_loader;
   localparam int AW  = 13;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   prog_loader_if #(.ADDR_WIDTH(AW)) bus ();
   logic cpu_hold, busy, load_done, load_error;

   prog_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done), .load_error(load_error)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   data;
      int            cyc;
   } wr_t;

   wr_t wq[$];
   int  cyc = 0;
   int  last_edge = 0;
   int  checks = 0;
   int  failures = 0;

   // Write log: sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (bus.wr_en === 1'b1) wq.push_back('{bus.wr_addr, bus.wr_data, cyc});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Drive one byte for one cycle; consecutive calls are back-to-back.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      last_edge    = cyc + 1;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic good_frame_1234();
      // checksum of 12 34 AB CD is 0xBE
      send(8'hA5); send(8'h00); send(8'h02);
      send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'hBE);
      idle(3);
   endtask

   int e0, e1, err_c;
   int errs;
   logic [7:0]  sum;
   logic [15:0] w;

   initial begin
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_wr_en", bus.wr_en, 0);
      check("rst_wr_addr", bus.wr_addr, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_flags", {cpu_hold, busy, load_done, load_error}, 4'b0000);

      // Good load with timing of each write pulse.
      wq.delete();
      send(8'hA5); send(8'h00); send(8'h02);
      @(posedge clk); #2;
      check("good_busy_mid", {busy, cpu_hold}, 2'b11);
      send(8'h12); send(8'h34); e0 = last_edge;
      send(8'hAB); send(8'hCD); e1 = last_edge;
      send(8'hBE);
      idle(3);
      check("good_nwr", wq.size(), 2);
      if (wq.size() == 2) begin
         check("good_w0", {3'b0, wq[0].addr, wq[0].data}, {3'b0, 13'h0000, 16'h1234});
         check("good_w1", {3'b0, wq[1].addr, wq[1].data}, {3'b0, 13'h0001, 16'hABCD});
         check("good_t0", wq[0].cyc, e0);
         check("good_t1", wq[1].cyc, e1);
      end
      check("good_flags", {cpu_hold, busy, load_done, load_error}, 4'b0010);

      // Bad checksum: writes still happen, CPU stays held.
      wq.delete();
      send(8'hA5); send(8'h00); send(8'h02);
      send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'h0F);
      idle(3);
      check("badchk_nwr", wq.size(), 2);
      check("badchk_flags", {cpu_hold, busy, load_done, load_error}, 4'b1001);
      good_frame_1234();
      check("rearm_flags", {cpu_hold, busy, load_done, load_error}, 4'b0010);

      // Length limits.
      wq.delete();
      send(8'hA5); send(8'h00); send(8'h00);
      idle(3);
      check("len0_flags", {cpu_hold, busy, load_done, load_error}, 4'b1001);
      check("len0_nwr", wq.size(), 0);
      send(8'hA5); send(8'h20); send(8'h01);
      idle(3);
      check("len8193_flags", {cpu_hold, busy, load_done, load_error}, 4'b1001);
      check("len8193_nwr", wq.size(), 0);

      // Full 8192-word image, word i = i.
      wq.delete();
      sum = 8'h00;
      send(8'hA5); send(8'h20); send(8'h00);
      for (int i = 0; i < 8192; i++) begin
         w = 16'(i);
         send(w[15:8]); send(w[7:0]);
         sum = sum + w[15:8] + w[7:0];
      end
      send(sum);
      idle(3);
      check("full_nwr", wq.size(), 8192);
      errs = 0;
      foreach (wq[i]) if (wq[i].addr !== 13'(i) || wq[i].data !== 16'(i)) errs++;
      check("full_words", errs, 0);
      if (wq.size() > 0) check("full_last_addr", wq[wq.size()-1].addr, 13'h1FFF);
      check("full_flags", {cpu_hold, busy, load_done, load_error}, 4'b0010);

      // Timeout after DATA_HI: error 15 cycles after the last byte.
      wq.delete();
      send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
      e0 = last_edge;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      err_c = -1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #2;
         if (load_error && err_c < 0) err_c = cyc;
      end
      check("tmo_delay", err_c - e0, 15);
      check("tmo_flags", {cpu_hold, busy, load_done, load_error}, 4'b1001);
      check("tmo_nwr", wq.size(), 0);

      // Noise in IDLE leaves everything untouched; sync inside data is data.
      send(8'h00); send(8'hFF); send(8'h5A);
      idle(3);
      check("noise_flags", {cpu_hold, busy, load_done, load_error}, 4'b1001);
      check("noise_nwr", wq.size(), 0);
      send(8'hA5); send(8'h00); send(8'h01); send(8'hA5); send(8'hA5); send(8'h4A);
      idle(3);
      check("esync_nwr", wq.size(), 1);
      if (wq.size() == 1) check("esync_w0", {3'b0, wq[0].addr, wq[0].data}, {3'b0, 13'h0000, 16'hA5A5});
      check("esync_flags", {cpu_hold, busy, load_done, load_error}, 4'b0010);

      // Asynchronous reset mid-frame.
      send(8'hA5); send(8'h00); send(8'h04); send(8'h12);
      @(posedge clk); #2;
      check("mid_busy", {busy, cpu_hold}, 2'b11);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_wr", {bus.wr_en, bus.wr_addr, bus.wr_data}, 30'h0);
      check("arst_flags", {cpu_hold, busy, load_done, load_error}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      wq.delete();
      send(8'hA5); send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h46);
      idle(3);
      check("post_rst_nwr", wq.size(), 1);
      if (wq.size() == 1) check("post_rst_w0", {3'b0, wq[0].addr, wq[0].data}, {3'b0, 13'h0000, 16'h1234});
      check("post_rst_flags", {cpu_hold, busy, load_done, load_error}, 4'b0010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
